// File: rtl/replay_pkg.sv
// Shared definitions for the packet replay sequencer: FSM state encoding
// and bit positions within the software control word.
package replay_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STORE  = 3'd1,
    S_STORED = 3'd2,
    S_REQ    = 3'd3,
    S_WAIT   = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int CTRL_START_STORE  = 0;
  localparam int CTRL_START_REPLAY = 1;
  localparam int CTRL_ABORT        = 2;

endpackage

// File: rtl/replay_edge_detect.sv
// Registered rising-edge detector for the software control levels.
// The first cycle after reset only loads the history, so levels that are
// still high when reset releases never look like a fresh edge.
module replay_edge_detect #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_prev;
  logic             r_hist_valid;

  // capture previous level; history becomes trustworthy one cycle after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev       <= '0;
      r_hist_valid <= 1'b0;
    end else begin
      r_prev       <= i_level;
      r_hist_valid <= 1'b1;
    end
  end

  assign o_rise = r_hist_valid ? (i_level & ~r_prev) : '0;

endmodule

// File: rtl/replay_sequencer.sv
// Replay engine sequencer: counts committed packets during the store phase,
// then requests each stored packet in order with an inter-frame gap,
// looping for a configured number of passes (or until abort).
//
//  state  | meaning
//  IDLE   | no valid store, waiting for start_store
//  STORE  | writer enabled, counting committed packets
//  STORED | store complete, waiting for start_replay/start_store
//  REQ    | one-cycle setup before requesting packet replay_idx
//  WAIT   | replay_req high until replay_ack
//  GAP    | inter-frame gap countdown
//  DONE   | all replay passes finished
module replay_sequencer
  import replay_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int IDX_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_DATA_WIDTH-1:0] i_ctrl_word,
  input  logic [AXI_DATA_WIDTH-1:0] i_pkt_count,
  input  logic [AXI_DATA_WIDTH-1:0] i_loop_count,
  input  logic [AXI_DATA_WIDTH-1:0] i_ifg_cycles,
  input  logic                      i_store_pkt_done,
  output logic                      o_store_en,
  output logic                      o_replay_req,
  output logic [IDX_WIDTH-1:0]      o_replay_idx,
  input  logic                      i_replay_ack,
  output logic                      o_compelete_store,
  output logic                      o_compelete_replay,
  output logic                      o_busy,
  output logic [AXI_DATA_WIDTH-1:0] o_sent_count
);

  state_t                    r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]      r_stored, w_stored_nxt;
  logic [IDX_WIDTH-1:0]      r_idx, w_idx_nxt;
  logic [AXI_DATA_WIDTH-1:0] r_loop, w_loop_nxt;
  logic [AXI_DATA_WIDTH-1:0] r_gap, w_gap_nxt;
  logic [AXI_DATA_WIDTH-1:0] r_sent, w_sent_nxt;
  logic                      r_cstore, w_cstore_nxt;
  logic                      r_creplay, w_creplay_nxt;

  logic [2:0]                w_rise;
  logic [IDX_WIDTH-1:0]      w_pkt;
  logic [IDX_WIDTH-1:0]      w_stored_inc;
  logic                      w_last;
  logic [IDX_WIDTH-1:0]      w_idx_adv;
  logic [AXI_DATA_WIDTH-1:0] w_loop_adv;
  logic                      w_done_adv;
  logic                      w_unused;

  replay_edge_detect #(.WIDTH(3)) u_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (i_ctrl_word[2:0]),
    .o_rise  (w_rise)
  );

  assign w_unused = ^{i_ctrl_word[AXI_DATA_WIDTH-1:3], i_pkt_count[AXI_DATA_WIDTH-1:IDX_WIDTH]};

  assign w_pkt        = i_pkt_count[IDX_WIDTH-1:0];
  assign w_stored_inc = r_stored + IDX_WIDTH'(i_store_pkt_done);

  // Next packet position once the current one (and its gap) is finished.
  assign w_last     = (r_idx == w_pkt - IDX_WIDTH'(1));
  assign w_idx_adv  = w_last ? '0 : r_idx + IDX_WIDTH'(1);
  assign w_loop_adv = w_last ? r_loop + AXI_DATA_WIDTH'(1) : r_loop;
  assign w_done_adv = w_last && (i_loop_count != '0) && (w_loop_adv == i_loop_count);

  // state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_stored  <= '0;
      r_idx     <= '0;
      r_loop    <= '0;
      r_gap     <= '0;
      r_sent    <= '0;
      r_cstore  <= 1'b0;
      r_creplay <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stored  <= w_stored_nxt;
      r_idx     <= w_idx_nxt;
      r_loop    <= w_loop_nxt;
      r_gap     <= w_gap_nxt;
      r_sent    <= w_sent_nxt;
      r_cstore  <= w_cstore_nxt;
      r_creplay <= w_creplay_nxt;
    end
  end

  // next-state and counter update; abort beats start_store beats start_replay
  always_comb begin
    w_state_nxt   = r_state;
    w_stored_nxt  = r_stored;
    w_idx_nxt     = r_idx;
    w_loop_nxt    = r_loop;
    w_gap_nxt     = r_gap;
    w_sent_nxt    = r_sent;
    w_cstore_nxt  = r_cstore;
    w_creplay_nxt = r_creplay;

    if (w_rise[CTRL_ABORT]) begin
      // compelete_store doubles as "stored data is valid"
      w_state_nxt   = r_cstore ? S_STORED : S_IDLE;
      w_creplay_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise[CTRL_START_STORE]) begin
            w_state_nxt   = S_STORE;
            w_stored_nxt  = '0;
            w_cstore_nxt  = 1'b0;
            w_creplay_nxt = 1'b0;
          end
        end
        S_STORE: begin
          w_stored_nxt = w_stored_inc;
          // comparing the incremented count lets completion show the cycle after the last pulse
          if ((r_stored == w_pkt) || (w_stored_inc == w_pkt)) begin
            w_state_nxt  = S_STORED;
            w_cstore_nxt = 1'b1;
          end
        end
        S_STORED, S_DONE: begin
          if (w_rise[CTRL_START_STORE]) begin
            w_state_nxt   = S_STORE;
            w_stored_nxt  = '0;
            w_cstore_nxt  = 1'b0;
            w_creplay_nxt = 1'b0;
          end else if (w_rise[CTRL_START_REPLAY]) begin
            w_idx_nxt     = '0;
            w_loop_nxt    = '0;
            w_sent_nxt    = '0;
            w_state_nxt   = (w_pkt == '0) ? S_DONE : S_REQ;
            w_creplay_nxt = (w_pkt == '0);
          end
        end
        S_REQ: begin
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (i_replay_ack) begin
            w_sent_nxt = (r_sent == '1) ? r_sent : r_sent + AXI_DATA_WIDTH'(1);
            if (i_ifg_cycles != '0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = i_ifg_cycles - AXI_DATA_WIDTH'(1);
            end else begin
              w_idx_nxt     = w_idx_adv;
              w_loop_nxt    = w_loop_adv;
              w_state_nxt   = w_done_adv ? S_DONE : S_REQ;
              w_creplay_nxt = w_done_adv;
            end
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            w_idx_nxt     = w_idx_adv;
            w_loop_nxt    = w_loop_adv;
            w_state_nxt   = w_done_adv ? S_DONE : S_REQ;
            w_creplay_nxt = w_done_adv;
          end else begin
            w_gap_nxt = r_gap - AXI_DATA_WIDTH'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign o_store_en         = (r_state == S_STORE);
  assign o_replay_req       = (r_state == S_WAIT);
  assign o_replay_idx       = r_idx;
  assign o_compelete_store  = r_cstore;
  assign o_compelete_replay = r_creplay;
  assign o_busy             = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_sent_count       = r_sent;

endmodule

// File: tb/tb_replay_sequencer.sv
// Directed bench for replay_sequencer: store, replay with gaps, abort,
// start collision, zero-length store/replay and reset mid-request.
module tb_replay_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ctrl_word, pkt_count, loop_count, ifg_cycles;
  logic        store_pkt_done, replay_ack;
  logic        store_en, replay_req, compelete_store, compelete_replay, busy;
  logic [15:0] replay_idx;
  logic [31:0] sent_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  replay_sequencer #(.AXI_DATA_WIDTH(32), .IDX_WIDTH(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_ctrl_word        (ctrl_word),
    .i_pkt_count        (pkt_count),
    .i_loop_count       (loop_count),
    .i_ifg_cycles       (ifg_cycles),
    .i_store_pkt_done   (store_pkt_done),
    .o_store_en         (store_en),
    .o_replay_req       (replay_req),
    .o_replay_idx       (replay_idx),
    .i_replay_ack       (replay_ack),
    .o_compelete_store  (compelete_store),
    .o_compelete_replay (compelete_replay),
    .o_busy             (busy),
    .o_sent_count       (sent_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    store_pkt_done = 1'b1;
    tick();
    store_pkt_done = 1'b0;
  endtask

  task automatic ack_once();
    replay_ack = 1'b1;
    tick();
    replay_ack = 1'b0;
  endtask

  // waits for replay_req; returns number of cycles waited (20 means timeout)
  task automatic wait_req(output int cnt);
    cnt = 0;
    while (!replay_req && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    total++;
    if ({store_en, replay_req, compelete_store, compelete_replay, busy} !== 5'b0 ||
        replay_idx !== 16'd0 || sent_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: flags=%b idx=%0d sent=%0d want all zero",
               {store_en, replay_req, compelete_store, compelete_replay, busy}, replay_idx, sent_count);
    end
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_store();
    pkt_count = 32'd3;
    ctrl_word = 32'd1;
    total++;
    if (store_en !== 1'b0) begin bad++; $display("FAIL store_en_before_edge: got %b want 0", store_en); end
    tick();
    total++;
    if (store_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL store_entry: store_en=%b busy=%b want 1 1", store_en, busy);
    end
    pulse_done();
    tick();
    pulse_done();
    total++;
    if (compelete_store !== 1'b0 || store_en !== 1'b1) begin
      bad++; $display("FAIL store_mid: cstore=%b store_en=%b want 0 1", compelete_store, store_en);
    end
    pulse_done();
    total++;
    if (compelete_store !== 1'b1 || store_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL store_complete: cstore=%b store_en=%b busy=%b want 1 0 1",
                      compelete_store, store_en, busy);
    end
  endtask

  task automatic test_replay_gap();
    int cnt;
    loop_count = 32'd2;
    ifg_cycles = 32'd4;
    ctrl_word  = 32'd0;
    tick();
    ctrl_word = 32'd2;
    tick();
    for (int k = 0; k < 6; k++) begin
      wait_req(cnt);
      total++;
      if (cnt !== ((k == 0) ? 1 : 5)) begin
        bad++; $display("FAIL gap_len[%0d]: req after %0d cycles want %0d", k, cnt, (k == 0) ? 1 : 5);
      end
      total++;
      if (replay_idx !== 16'(k % 3)) begin
        bad++; $display("FAIL gap_idx[%0d]: got %0d want %0d", k, replay_idx, k % 3);
      end
      ack_once();
      total++;
      if (replay_req !== 1'b0 || sent_count !== 32'(k + 1)) begin
        bad++; $display("FAIL gap_ack[%0d]: req=%b sent=%0d want 0 %0d", k, replay_req, sent_count, k + 1);
      end
    end
    cnt = 0;
    while (!compelete_replay && cnt < 20) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt !== 4 || sent_count !== 32'd6 || busy !== 1'b0 || replay_req !== 1'b0) begin
      bad++; $display("FAIL gap_done: cycles=%0d sent=%0d busy=%b req=%b want 4 6 0 0",
                      cnt, sent_count, busy, replay_req);
    end
  endtask

  task automatic test_abort();
    int cnt;
    loop_count = 32'd0;
    ifg_cycles = 32'd0;
    ctrl_word  = 32'd0;
    tick();
    ctrl_word = 32'd2;
    tick();
    for (int k = 0; k < 10; k++) begin
      wait_req(cnt);
      total++;
      if (cnt !== 1 || replay_idx !== 16'(k % 3)) begin
        bad++; $display("FAIL loop_pkt[%0d]: wait=%0d idx=%0d want 1 %0d", k, cnt, replay_idx, k % 3);
      end
      ack_once();
    end
    wait_req(cnt);
    total++;
    if (replay_req !== 1'b1 || sent_count !== 32'd10) begin
      bad++; $display("FAIL loop_count10: req=%b sent=%0d want 1 10", replay_req, sent_count);
    end
    ctrl_word = 32'd6;
    tick();
    total++;
    if (replay_req !== 1'b0 || store_en !== 1'b0 || busy !== 1'b1 ||
        compelete_store !== 1'b1 || compelete_replay !== 1'b0) begin
      bad++; $display("FAIL abort: req=%b store_en=%b busy=%b cstore=%b creplay=%b want 0 0 1 1 0",
                      replay_req, store_en, busy, compelete_store, compelete_replay);
    end
    tick(); tick();
    total++;
    if (replay_req !== 1'b0) begin bad++; $display("FAIL abort_hold: req=%b want 0", replay_req); end
  endtask

  task automatic test_simultaneous();
    ctrl_word = 32'd0;
    tick();
    ctrl_word = 32'd3;
    tick();
    total++;
    if (store_en !== 1'b1 || compelete_store !== 1'b0 || replay_req !== 1'b0) begin
      bad++; $display("FAIL both_starts: store_en=%b cstore=%b req=%b want 1 0 0",
                      store_en, compelete_store, replay_req);
    end
    tick(); tick();
    total++;
    if (replay_req !== 1'b0 || store_en !== 1'b1) begin
      bad++; $display("FAIL both_starts_hold: req=%b store_en=%b want 0 1", replay_req, store_en);
    end
    pulse_done(); pulse_done(); pulse_done();
    total++;
    if (compelete_store !== 1'b1 || store_en !== 1'b0) begin
      bad++; $display("FAIL both_starts_store: cstore=%b store_en=%b want 1 0", compelete_store, store_en);
    end
  endtask

  task automatic test_zero_pkt();
    pkt_count = 32'd0;
    ctrl_word = 32'd0;
    tick();
    ctrl_word = 32'd1;
    tick();
    total++;
    if (store_en !== 1'b1 || compelete_store !== 1'b0) begin
      bad++; $display("FAIL zero_store_entry: store_en=%b cstore=%b want 1 0", store_en, compelete_store);
    end
    tick();
    total++;
    if (store_en !== 1'b0 || compelete_store !== 1'b1) begin
      bad++; $display("FAIL zero_store_done: store_en=%b cstore=%b want 0 1", store_en, compelete_store);
    end
    ctrl_word = 32'd0;
    tick();
    ctrl_word = 32'd2;
    tick();
    total++;
    if (compelete_replay !== 1'b1 || sent_count !== 32'd0 || busy !== 1'b0 || replay_req !== 1'b0) begin
      bad++; $display("FAIL zero_replay: creplay=%b sent=%0d busy=%b req=%b want 1 0 0 0",
                      compelete_replay, sent_count, busy, replay_req);
    end
    tick(); tick();
    total++;
    if (replay_req !== 1'b0) begin bad++; $display("FAIL zero_replay_req: req=%b want 0", replay_req); end
  endtask

  task automatic test_reset_midway();
    pkt_count = 32'd3;
    ctrl_word = 32'd0;
    tick();
    ctrl_word = 32'd1;
    tick();
    pulse_done(); pulse_done(); pulse_done();
    ctrl_word = 32'd3;
    tick(); tick();
    total++;
    if (replay_req !== 1'b1 || replay_idx !== 16'd0) begin
      bad++; $display("FAIL midway_req: req=%b idx=%0d want 1 0", replay_req, replay_idx);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({store_en, replay_req, compelete_store, compelete_replay, busy} !== 5'b0 || sent_count !== 32'd0) begin
      bad++; $display("FAIL midway_reset: flags=%b sent=%0d want 0 0",
                      {store_en, replay_req, compelete_store, compelete_replay, busy}, sent_count);
    end
    reset = 1'b0;
    tick(); tick(); tick();
    total++;
    if (busy !== 1'b0 || store_en !== 1'b0 || replay_req !== 1'b0) begin
      bad++; $display("FAIL midway_no_restart: busy=%b store_en=%b req=%b want 0 0 0",
                      busy, store_en, replay_req);
    end
  endtask

  initial begin
    reset          = 1'b1;
    ctrl_word      = 32'd0;
    pkt_count      = 32'd0;
    loop_count     = 32'd0;
    ifg_cycles     = 32'd0;
    store_pkt_done = 1'b0;
    replay_ack     = 1'b0;
    test_reset();
    test_store();
    test_replay_gap();
    test_abort();
    test_simultaneous();
    test_zero_pkt();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
